// File: rtl/bus_fifo_port_pkg.sv
// Register offsets and STATUS/CTRL bit positions for the bus FIFO peripheral.
package bus_fifo_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_TX_COUNT_LSB = 0;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_COUNT_W      = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_RX_EMPTY     = 17;
  localparam int ST_TX_OVF       = 18;
  localparam int ST_RX_UNF       = 19;

  localparam int CTRL_TX_FLUSH   = 0;
  localparam int CTRL_RX_FLUSH   = 1;
  localparam int CTRL_TX_OVF_CLR = 2;
  localparam int CTRL_RX_UNF_CLR = 3;

endpackage

// File: rtl/bus_fifo_port_if.sv
// CPU data-bus slave signals plus the TX sink and RX source streams.
interface bus_fifo_port_if;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;

  modport slave (
    input  addr, cs, wr_rd, data_bus_write, tx_ready, rx_valid, rx_data,
    output data_bus_read, tx_valid, tx_data, rx_ready
  );

  modport master (
    output addr, cs, wr_rd, data_bus_write, tx_ready, rx_valid, rx_data,
    input  data_bus_read, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/bus_fifo_port_fifo.sv
// Synchronous FIFO with flush; caller guarantees push/pop legality (push on full only with pop).
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; the empty gate below hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_fifo_port.sv
// Memory-mapped TX/RX FIFO peripheral: address decode, read mux, sticky flags, stream gating.
module bus_fifo_port
  import bus_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  bus_fifo_port_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] tx_count, rx_count;
  logic [31:0]      tx_head, rx_head;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [1:0]       offset;
  logic             bus_wr, bus_rd, ctrl_wr;
  logic             tx_push_req, tx_push, tx_pop, rx_pop_req, rx_push, rx_pop;
  logic             tx_flush, rx_flush;
  logic [31:0]      status;
  logic             unused_addr;

  assign offset      = bus.addr[3:2];
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign bus_wr      = bus.cs & bus.wr_rd;
  assign bus_rd      = bus.cs & ~bus.wr_rd;
  assign ctrl_wr     = bus_wr && (offset == OFF_CTRL);

  assign tx_flush = ctrl_wr & bus.data_bus_write[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & bus.data_bus_write[CTRL_RX_FLUSH];

  // A write into a full TX FIFO is only accepted when the sink frees a slot that same edge.
  assign tx_pop      = ~tx_empty & bus.tx_ready;
  assign tx_push_req = bus_wr && (offset == OFF_TXDATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  assign rx_pop_req = bus_rd && (offset == OFF_RXDATA);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = bus.rx_valid & ~rx_full;

  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.rx_ready = ~rx_full;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush),
    .push(tx_push), .push_data(bus.data_bus_write), .pop(tx_pop),
    .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush),
    .push(rx_push), .push_data(bus.rx_data), .pop(rx_pop),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  // Set beats clear when both land on the same edge.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (ctrl_wr && bus.data_bus_write[CTRL_TX_OVF_CLR]) tx_ovf_d = 1'b0;
    if (ctrl_wr && bus.data_bus_write[CTRL_RX_UNF_CLR]) rx_unf_d = 1'b0;
    if (tx_push_req && tx_full && !bus.tx_ready)        tx_ovf_d = 1'b1;
    if (rx_pop_req && rx_empty)                         rx_unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
    status[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_UNF]   = rx_unf_q;
  end

  always_comb begin
    bus.data_bus_read = '0;
    if (bus_rd) begin
      case (offset)
        OFF_RXDATA: bus.data_bus_read = rx_head;
        OFF_STATUS: bus.data_bus_read = status;
        default:    bus.data_bus_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed bench for bus_fifo_port: register map, FIFO boundaries, flush and reset abort.
module tb_bus_fifo_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_fifo_port_if bus ();

  bus_fifo_port #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.cs = 1'b1; bus.wr_rd = 1'b1; bus.data_bus_write = d;
    step();
    bus.cs = 1'b0; bus.wr_rd = 1'b0;
  endtask

  // Combinational peek of a read-only location; does not cross a clock edge.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.cs = 1'b1; bus.wr_rd = 1'b0;
    #1;
    d = bus.data_bus_read;
    bus.cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000) begin miscompares++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0002_0000); end
    vectors++;
    if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    vectors++;
    if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
    vectors++;
    if (bus.tx_data !== 32'h0) begin miscompares++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    peek(32'h0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL txdata_read got=%h exp=0", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) bus_wr(32'h0, 32'hA5A5_0000 + i);
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0003_0008) begin miscompares++; $display("FAIL tx_full_status got=%h exp=%h", d, 32'h0003_0008); end
    bus_wr(32'h0, 32'hA5A5_0009);
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0007_0008) begin miscompares++; $display("FAIL tx_ovf_status got=%h exp=%h", d, 32'h0007_0008); end
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'hA5A5_0000 + i) begin
        miscompares++;
        $display("FAIL tx_drain[%0d] got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, 32'hA5A5_0000 + i);
      end
      step();
    end
    vectors++;
    if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_drained_valid got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
    bus_wr(32'hC, 32'h4);
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000) begin miscompares++; $display("FAIL tx_ovf_clear got=%h exp=%h", d, 32'h0002_0000); end
  endtask

  task automatic test_tx_full_replace();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) bus_wr(32'h0, 32'hA5A5_0000 + i);
    bus.tx_ready = 1'b1;
    bus.addr = 32'h0; bus.cs = 1'b1; bus.wr_rd = 1'b1; bus.data_bus_write = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (bus.tx_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL replace_head got=%h exp=%h", bus.tx_data, 32'hA5A5_0001); end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr_rd = 1'b0; bus.tx_ready = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0003_0008) begin miscompares++; $display("FAIL replace_status got=%h exp=%h", d, 32'h0003_0008); end
    bus.tx_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      vectors++;
      if (bus.tx_data !== ((i == 9) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + i)) begin
        miscompares++;
        $display("FAIL replace_drain[%0d] got=%h", i, bus.tx_data);
      end
      step();
    end
    bus.tx_ready = 1'b0;
    vectors++;
    if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL replace_empty got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_rx_stream();
    logic [31:0] d;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33; exp_rd[3] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = exp_rd[i];
      step();
    end
    bus.rx_valid = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0000_0300) begin miscompares++; $display("FAIL rx_count3 got=%h exp=%h", d, 32'h0000_0300); end
    bus.addr = 32'h4; bus.cs = 1'b1; bus.wr_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (bus.data_bus_read !== exp_rd[i]) begin
        miscompares++;
        $display("FAIL rx_read[%0d] got=%h exp=%h", i, bus.data_bus_read, exp_rd[i]);
      end
      @(posedge clk); #1;
    end
    bus.cs = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h000A_0000) begin miscompares++; $display("FAIL rx_unf_status got=%h exp=%h", d, 32'h000A_0000); end
    bus_wr(32'hC, 32'h8);
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000) begin miscompares++; $display("FAIL rx_unf_clear got=%h exp=%h", d, 32'h0002_0000); end
  endtask

  task automatic test_rx_full();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 32'h100 + i;
      #1;
      vectors++;
      if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL rx_fill_ready[%0d] got=%b exp=1", i, bus.rx_ready); end
      @(posedge clk); #1;
    end
    bus.rx_data = 32'h1FF;
    vectors++;
    if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready got=%b exp=0", bus.rx_ready); end
    step();
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0000_0800) begin miscompares++; $display("FAIL rx_full_status got=%h exp=%h", d, 32'h0000_0800); end
    bus.addr = 32'h4; bus.cs = 1'b1; bus.wr_rd = 1'b0;
    #1;
    vectors++;
    if (bus.data_bus_read !== 32'h100 || bus.rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_full_pop got=%h/%b exp=%h/0", bus.data_bus_read, bus.rx_ready, 32'h100);
    end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rx_valid = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0000_0700) begin miscompares++; $display("FAIL rx_full_pop_status got=%h exp=%h", d, 32'h0000_0700); end
    bus_wr(32'hC, 32'h2);
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000 || bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_flush got=%h/%b exp=%h/1", d, bus.rx_ready, 32'h0002_0000);
    end
  endtask

  task automatic test_tx_flush();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_wr(32'h0, 32'h50 + i);
    bus.tx_ready = 1'b1;
    bus_wr(32'hC, 32'h1);
    bus.tx_ready = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000 || bus.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_flush got=%h/%b exp=%h/0", d, bus.tx_valid, 32'h0002_0000);
    end
    bus_wr(32'h0, 32'h77);
    vectors++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'h77) begin
      miscompares++;
      $display("FAIL tx_after_flush got=%b/%h exp=1/%h", bus.tx_valid, bus.tx_data, 32'h77);
    end
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_wr(32'h0, 32'h60 + i);
    bus.tx_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    peek(32'h8, d);
    vectors++;
    if (d !== 32'h0002_0000 || bus.tx_valid !== 1'b0 || bus.tx_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid got=%h/%b/%h exp=%h/0/0", d, bus.tx_valid, bus.tx_data, 32'h0002_0000);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_handshake[%0d] got=%b exp=0", i, bus.tx_valid); end
    end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    bus.addr = '0; bus.cs = 1'b0; bus.wr_rd = 1'b0; bus.data_bus_write = '0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    #1;
    test_reset();
    test_tx_overflow();
    test_tx_full_replace();
    test_rx_stream();
    test_rx_full();
    test_tx_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_fifo_port.md
# bus_fifo_port

Memory-mapped dual-FIFO peripheral on the CPU's external data bus, downstream of the memory stage. Consumes `addr`, `cs`, `wr_rd` and `data_bus_write`, and returns `data_bus_read` in the same cycle. A TX FIFO drains CPU writes to an external valid/ready sink. An RX FIFO buffers words from an external valid/ready source for CPU reads. Status and control registers expose occupancy, sticky error flags and flush controls.

## Interface
- `DEPTH`, 8: entries per FIFO; power of two, 2..128.
- `clk`  in  1  rising-edge clock; one clock, with `rst` synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  bus address; only `addr[3:2]` decoded.
- `cs`  in  1  peripheral select. When 1, the CPU routes `data_bus_read` into write-back.
- `wr_rd`  in  1  1 = write, 0 = read. Qualified by `cs`.
- `data_bus_write`  in  32  CPU store data.
- `data_bus_read`  out  32  read data; combinational from `addr`/state.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  sink accepts the head word.
- `tx_data`  out  32  TX head word.
- `rx_valid`  in  1  source offers a word.
- `rx_ready`  out  1  RX FIFO not full.
- `rx_data`  in  32  source word.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 TXDATA: write-only. A write pushes to the TX FIFO. Reads return 0.
  - 1 RXDATA: read-only. A read returns the RX head and pops it. Writes are ignored.
  - 2 STATUS: read-only.
    - [7:0] tx_count, [15:8] rx_count
    - [16] tx_full, [17] rx_empty
    - [18] tx_overflow, [19] rx_underflow
    - remaining bits 0
  - 3 CTRL: write-only. Reads return 0.
    - bit0 flushes TX, bit1 flushes RX.
    - bit2 clears tx_overflow, bit3 clears rx_underflow.
- Bus access qualifier: `cs`. Write = `cs & wr_rd`. Read = `cs & ~wr_rd`. Every qualified access is a single-cycle, side-effect event at the next edge.
- TX full + TXDATA write:
  - if `tx_ready` is also 1, the pop and push both occur and the count is unchanged;
  - otherwise the word is dropped and tx_overflow is set (sticky).
- RX empty + RXDATA read: `data_bus_read` = 0, no pop, rx_underflow is set (sticky).
- RX full + CPU RXDATA pop in the same cycle: `rx_ready` stays 0 (registered-full based). The source word is not taken.
- Stream transfer occurs on a cycle where valid & ready are both 1. `tx_data` is stable while `tx_valid` = 1 and `tx_ready` = 0.
- Flush: count, read pointer and write pointer go to 0.
  - Flush wins over a same-cycle push or pop on that FIFO.
  - Stored data is not cleared.
- Sticky-flag priority: a same-cycle set and clear leaves the flag set.
- Counts are `$clog2(DEPTH+1)` bits, zero-extended into STATUS fields. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - all counts and pointers 0; both flags 0
  - `tx_valid` 0, `rx_ready` 1, `tx_data` 0
  - `data_bus_read` = 0 unless `cs & ~wr_rd` selects STATUS (reads 0x0002_0000 after reset)
- `rst` asserted mid-transfer aborts all pending pushes and pops. `rst` has priority over every other event.
- Read latency 0: `data_bus_read` is valid in the cycle `cs` and `addr` are presented. The pop takes effect at that edge.
- Push latency 1: after a TXDATA write at edge N, `tx_valid` = 1 and `tx_data` = word from edge N (if the FIFO was empty).
- RX word accepted at edge N: readable via RXDATA from cycle N+1.
- STATUS reflects the registered state before the current edge.
- Back-to-back RXDATA reads on consecutive cycles return consecutive entries.

## Structure
- Package `bus_fifo_pkg`: offset constants `OFF_TXDATA`=2'd0, `OFF_RXDATA`=2'd1, `OFF_STATUS`=2'd2, `OFF_CTRL`=2'd3, plus STATUS and CTRL bit-position constants.
- One sub-module, `sync_fifo`, instantiated twice (TX, RX).
  - Ports: clk, rst, flush, push, push_data, pop, head, count, full, empty.
  - Simultaneous push and pop allowed when full.
- Top level holds address decode, the read mux, sticky flags and FIFO handshake gating.

## Test plan
- Reset, then read STATUS → 0x0002_0000; `tx_valid`=0; `rx_ready`=1.
- Write 0xA5A5_0001 .. 0xA5A5_0008 to TXDATA with `tx_ready`=0 → STATUS tx_count=8, tx_full=1. A ninth write sets bit18, and the TX contents stay 0x..01..08. Raising `tx_ready` drains exactly 01..08 in order, one per cycle.
- TX full, simultaneous write of 0xDEAD_BEEF with `tx_ready`=1 → count stays 8, no overflow, 0xDEAD_BEEF emerges last.
- Source pushes 0x11, 0x22, 0x33 → RXDATA reads on consecutive cycles return 0x11, 0x22, 0x33. A fourth read returns 0 and sets bit19. Writing CTRL=0x8 clears bit19.
- Fill RX to 8 with `rx_valid` held high → `rx_ready`=0 and the ninth word is not taken. Writing CTRL=0x2 gives rx_count=0 and `rx_ready`=1 the next cycle.
- Assert `rst` during a TX drain with 5 words queued → next cycle tx_count=0, `tx_valid`=0, and no further handshakes.
